// File: rtl/rc_servo.sv
// rc_servo: RC-servo joint output.
//
// Integrates a signed step-period command into a saturating position
// counter, reports that position as joint feedback, and drives a hobby-servo
// PWM whose pulse width is CENTER + position, latched once per frame.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   rst            asynchronous active-high reset
//   jointFreqCmd   signed step period in clk cycles; sign = direction, 0 = hold
//   jointFeedback  signed position, in clk cycles of pulse offset from CENTER
//   PWM            registered servo pulse output
module rc_servo #(
    parameter int CLK_FREQ  = 48000000,
    parameter int SERVO_FRQ = 100,
    parameter int CENTER_US = 1500,
    parameter int RANGE_US  = 500
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [31:0] jointFreqCmd,
    output logic signed [31:0] jointFeedback,
    output logic               PWM
);

    localparam int PERIOD = CLK_FREQ / SERVO_FRQ;
    localparam int CENTER = CLK_FREQ / 1000000 * CENTER_US;
    localparam int RANGE  = CLK_FREQ / 1000000 * RANGE_US;

    localparam logic        [31:0] PERIOD_LAST = 32'(PERIOD - 1);
    localparam logic        [31:0] CENTER_U    = 32'(CENTER);
    localparam logic signed [31:0] CENTER_S    = 32'(CENTER);
    localparam logic signed [31:0] RANGE_S     = 32'(RANGE);

    // The widest pulse must still leave a low gap inside every frame.
    if (CENTER + RANGE >= PERIOD) begin : g_bad_params
        $error("rc_servo: CENTER + RANGE must be smaller than PERIOD");
    end

    // Magnitude of the command as unsigned; -2^31 negates to 2^31, which is
    // exactly the desired unsigned magnitude.
    function automatic logic [31:0] cmd_abs(input logic signed [31:0] c);
        logic signed [31:0] neg;
        neg = -c;
        return c[31] ? $unsigned(neg) : $unsigned(c);
    endfunction

    // One position step towards +RANGE (up) or -RANGE (down), saturating.
    function automatic logic signed [31:0] pos_step(
        input logic signed [31:0] pos,
        input logic               up
    );
        if (up) begin
            return (pos < RANGE_S) ? pos + 32'sd1 : pos;
        end
        return (pos > -RANGE_S) ? pos - 32'sd1 : pos;
    endfunction

    logic        [31:0] step_cnt_q, step_cnt_d;
    logic signed [31:0] pos_q, pos_d;
    logic        [31:0] frame_cnt_q, frame_cnt_d;
    logic        [31:0] width_q, width_d;
    logic               pwm_q, pwm_d;

    logic        [31:0] abs_cmd;
    logic               step;

    always_comb begin
        abs_cmd     = cmd_abs(jointFreqCmd);
        step        = 1'b0;
        step_cnt_d  = step_cnt_q;
        pos_d       = pos_q;
        frame_cnt_d = frame_cnt_q;
        width_d     = width_q;
        pwm_d       = 1'b0;

        // Step generator: the counter is never cleared on a command change,
        // so a shorter new period that the counter already exceeds fires
        // immediately.
        if (abs_cmd == 32'd0) begin
            step_cnt_d = 32'd0;
        end else if (step_cnt_q >= abs_cmd - 32'd1) begin
            step_cnt_d = 32'd0;
            step       = 1'b1;
        end else begin
            step_cnt_d = step_cnt_q + 32'd1;
        end

        // A step only happens with a nonzero command, so a clear sign bit
        // means a positive direction.
        if (step) begin
            pos_d = pos_step(pos_q, !jointFreqCmd[31]);
        end

        // PWM frame
        if (frame_cnt_q == PERIOD_LAST) begin
            frame_cnt_d = 32'd0;
        end else begin
            frame_cnt_d = frame_cnt_q + 32'd1;
        end

        // Width is sampled only at the frame start so position changes
        // mid-frame never distort the pulse in flight.
        if (frame_cnt_q == 32'd0) begin
            width_d = $unsigned(CENTER_S + pos_q);
        end

        // Comparing against the freshly latched width keeps the high time
        // equal to the latched width for the frame being started.
        pwm_d = (frame_cnt_q < width_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt_q  <= 32'd0;
            pos_q       <= 32'sd0;
            frame_cnt_q <= 32'd0;
            width_q     <= CENTER_U;
            pwm_q       <= 1'b0;
        end else begin
            step_cnt_q  <= step_cnt_d;
            pos_q       <= pos_d;
            frame_cnt_q <= frame_cnt_d;
            width_q     <= width_d;
            pwm_q       <= pwm_d;
        end
    end

    assign jointFeedback = pos_q;
    assign PWM           = pwm_q;

endmodule

// File: tb/tb_rc_servo.sv
// Testbench for rc_servo: directed and randomized step commands, every cycle
// scored against a frame/step-level reference model through queues.
module tb_rc_servo;

    localparam int P      = 20000;
    localparam int CENTER = 1500;
    localparam int RANGE  = 500;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [31:0] cmd = 32'sd0;
    logic signed [31:0] fb;
    logic               pwm;

    rc_servo #(
        .CLK_FREQ (1000000),
        .SERVO_FRQ(50),
        .CENTER_US(1500),
        .RANGE_US (500)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .jointFreqCmd (cmd),
        .jointFeedback(fb),
        .PWM          (pwm)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard queues: one entry per clock edge, one width per frame.
    longint exp_fb_q[$];
    bit     exp_pwm_q[$];
    int     exp_w_q[$];

    // Reference model state
    longint m_elapsed;  // cycles accumulated towards the next step
    longint m_pos;      // position
    longint m_k;        // clock edges since reset release
    longint m_w;        // pulse width of the current frame

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_elapsed = 0;
        m_pos     = 0;
        m_k       = 0;
        m_w       = CENTER;
    endtask

    // Drive one command for the coming rising edge, predict the outcome, then
    // move on to the next falling edge.
    task automatic drive(input logic signed [31:0] c);
        longint a;
        longint ph;
        bit     stp;
        cmd = c;
        m_k++;
        a   = (c < 0) ? -longint'(c) : longint'(c);
        stp = 1'b0;
        if (a == 0) begin
            m_elapsed = 0;
        end else if (m_elapsed >= a - 1) begin
            m_elapsed = 0;
            stp = 1'b1;
        end else begin
            m_elapsed++;
        end
        ph = (m_k - 1) % P;
        if (ph == 0) begin
            m_w = CENTER + m_pos;
            exp_w_q.push_back(int'(m_w));
        end
        if (stp) begin
            if (c > 0 && m_pos < RANGE) m_pos++;
            else if (c < 0 && m_pos > -RANGE) m_pos--;
        end
        exp_fb_q.push_back(m_pos);
        exp_pwm_q.push_back(ph < m_w);
        @(negedge clk);
    endtask

    task automatic run(input logic signed [31:0] c, input int n);
        repeat (n) drive(c);
    endtask

    // Monitor: scores every edge and measures every completed PWM pulse.
    initial begin
        int hi_run;
        hi_run = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                check("pwm_in_reset", pwm, 0);
                check("fb_in_reset", fb, 0);
                hi_run = 0;
            end else begin
                if (exp_fb_q.size() > 0) begin
                    check("feedback", fb, exp_fb_q.pop_front());
                    check("pwm", pwm, exp_pwm_q.pop_front());
                end
                if (pwm) begin
                    hi_run++;
                end else if (hi_run > 0) begin
                    if (exp_w_q.size() > 0) check("pulse_width", hi_run, exp_w_q.pop_front());
                    else check("pulse_unexpected", hi_run, 0);
                    hi_run = 0;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [31:0] rc;
        int                 sel;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle: one full frame at the neutral width
        run(0, P);
        check("fb_idle", fb, 0);

        // +100 from idle: one step every 100 cycles
        run(100, 10000);
        check("fb_after_p100", fb, 100);

        // -1 past the lower limit
        run(-1, 700);
        check("fb_sat_low", fb, -RANGE);

        // +1 past the upper limit, then hold across a frame boundary
        run(1, 1200);
        check("fb_sat_high", fb, RANGE);
        run(0, 10500);
        check("fb_hold", fb, RANGE);

        // Period 128, then switch to a very long period mid-count
        run(-128, 1000);
        check("fb_after_m128", fb, RANGE - 7);
        run(-128000, 2000);
        check("fb_after_m128000", fb, RANGE - 7);

        // Counter already beyond the new shorter period
        run(-200, 150);
        run(50, 120);

        // Randomized segments
        for (int s = 0; s < 20; s++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0: rc = 32'sd0;
                1: rc = 32'sh80000000;
                2: rc = 32'($urandom_range(1, 3));
                default: rc = 32'($urandom_range(1, 300));
            endcase
            if ($urandom_range(0, 1) == 1 && sel != 1) rc = -rc;
            run(rc, int'($urandom_range(50, 400)));
        end

        // Bring position to 300 and reset in the middle of its pulse
        run(-1, 1000);
        check("fb_sat_low_2", fb, -RANGE);
        run(1, 800);
        check("fb_300", fb, 300);
        while (!((m_k % P) == 200 && m_w == CENTER + 300)) drive(0);
        check("pwm_mid_pulse", pwm, 1);
        #2;
        rst = 1'b1;
        #1;
        check("pwm_async_reset", pwm, 0);
        check("fb_async_reset", fb, 0);
        exp_w_q.delete();
        model_reset();
        repeat (4) @(negedge clk);
        rst = 1'b0;

        // First frame after reset is neutral again
        run(0, 1600);
        check("fb_after_reset", fb, 0);
        check("scoreboard_drained", exp_fb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rc_servo.md
Name: rc_servo

Overview:
- RC-servo joint output for the RIO joint plugin set.
- Integrates a signed step-rate command (clock cycles per step, sign = direction) into a saturating position counter.
- Reports that position as joint feedback.
- Drives a standard hobby-servo PWM: fixed frame, pulse width = centre + position.

Parameters:
CLK_FREQ, 48000000, system clock frequency in Hz.
SERVO_FRQ, 100, PWM frame rate in Hz; frame length PERIOD = CLK_FREQ/SERVO_FRQ cycles.
CENTER_US, 1500, neutral pulse width in microseconds; CENTER = CLK_FREQ/1000000*CENTER_US cycles.
RANGE_US, 500, max deviation from centre in microseconds; RANGE = CLK_FREQ/1000000*RANGE_US cycles.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous active-high reset.
jointFreqCmd  input  32 signed  step period in clk cycles; sign = direction; 0 = hold.
jointFeedback  output  32 signed  current position, units of clk cycles of pulse offset.
PWM  output  1  servo pulse output, registered.

Behaviour:
- Elaboration-time constraint: CENTER+RANGE < PERIOD.
- Reset (async, rst=1): step counter=0, position=0, frame counter=0, latched width=CENTER, PWM=0.
- Reset has priority over all other activity, including reset asserted mid-frame.
- Step generator:
  - abs = |jointFreqCmd| as 32-bit unsigned; -2^31 maps to 2^31.
  - abs==0: step counter held at 0, no steps.
  - Otherwise the counter increments each cycle.
  - When counter >= abs-1: counter<=0 and one step is issued in that cycle.
  - Consequence: abs=1 steps every cycle; abs=N steps every N cycles; first step N cycles after the command becomes nonzero from an idle counter.
  - Command change mid-count: counter not cleared. If the counter is already >= new abs-1, step on the next cycle.
- Position:
  - Step with cmd>0 increments position; step with cmd<0 decrements it.
  - Saturates at +RANGE / -RANGE; steps beyond a limit are ignored.
  - jointFeedback = position register, same-cycle visible after update, no extra latency.
- PWM frame:
  - Frame counter runs 0..PERIOD-1, then wraps.
  - When the frame counter==0, latched width <= CENTER + position.
  - Mid-frame position changes affect only the next frame.
  - PWM register <= (frame counter < latched width). One cycle latency vs the counter.
  - High time per frame is exactly latched-width cycles; period exactly PERIOD cycles.
- Width always in [CENTER-RANGE, CENTER+RANGE], guaranteed by position saturation. No extra clamp required, but permitted.
- No handshake; command sampled every cycle.

Test Plan:
- Test parameters for all scenarios: CLK_FREQ=1000000, SERVO_FRQ=50 (PERIOD 20000, CENTER 1500, RANGE 500).
- Reset, then cmd=0 for 3 frames -> jointFeedback=0. PWM high exactly 1500 cycles in each 20000-cycle frame; PWM=0 while rst=1.
- cmd=+100 from idle -> feedback increments at cycles 100, 200, ... Feedback=100 after 10000 cycles. Following frame pulse = CENTER + latched position (e.g. 1600 if latched at 100).
- cmd=-1 for 600 cycles -> feedback decrements every cycle and stops at -500. Subsequent frames pulse 1000 cycles.
- cmd=+1 for 1200 cycles -> feedback saturates at +500. Pulse 2000 cycles, then cmd=0 holds 500 indefinitely.
- cmd=+128 then switch to +128000 mid-run -> step spacing changes from 128 to 128000 cycles; no spurious extra steps except the rule for counter >= abs-1.
- Assert rst mid-pulse with feedback=300 -> PWM and jointFeedback drop to 0 immediately without waiting for a clock edge. After release, first frame pulse 1500.
